// File: rtl/led_pwm_pio_if.sv
// Avalon-MM slave bus bundle for the LED PWM peripheral.
// No waitrequest. Read data arrives one cycle after the read strobe.
interface led_pwm_pio_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] avs_address;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic              avs_read;
    logic [31:0]       avs_readdata;
    logic              avs_readdatavalid;

    modport master (
        output avs_address, avs_write, avs_writedata, avs_read,
        input  avs_readdata, avs_readdatavalid
    );
    modport slave (
        input  avs_address, avs_write, avs_writedata, avs_read,
        output avs_readdata, avs_readdatavalid
    );
endinterface

// File: rtl/led_pwm_pio.sv
// N_CH LED outputs. Each channel is either a static bit or a PWM dimmer.
// A new duty value takes effect only at a PWM counter wrap, so it never glitches.
module led_pwm_ch #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                duty_we,
    input  logic [PWM_BITS:0]   duty_wdata,
    input  logic                wrap,
    input  logic [PWM_BITS-1:0] cnt,
    input  logic                mode,
    input  logic                data,
    output logic [PWM_BITS:0]   duty,
    output logic                led
);
    logic [PWM_BITS:0] duty_q, duty_d, active_q, active_d;
    logic              led_q, led_d, pwm;

    always_comb begin
        duty_d   = duty_we ? duty_wdata : duty_q;
        // active_q loads the pre-write shadow, so a write in the wrap cycle waits one more period
        active_d = wrap ? duty_q : active_q;
        pwm      = {1'b0, cnt} < active_q;
        led_d    = mode ? pwm : data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_q   <= '0;
            active_q <= '0;
            led_q    <= 1'b0;
        end else begin
            duty_q   <= duty_d;
            active_q <= active_d;
            led_q    <= led_d;
        end
    end

    assign duty = duty_q;
    assign led  = led_q;
endmodule

module led_pwm_pio #(
    parameter int N_CH     = 4,
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 50,
    parameter int ADDR_W   = 4
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    led_pwm_pio_if.slave      avs,
    output logic [N_CH-1:0]   led_export,
    output logic              pwm_wrap
);
    localparam int PC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PC_W-1:0]                 pcnt_q, pcnt_d;
    logic [PWM_BITS-1:0]             cnt_q, cnt_d;
    logic                            pwm_wrap_q, tick, wrap;
    logic [N_CH-1:0]                 data_q, data_d, mode_q, mode_d, duty_we;
    logic [N_CH-1:0][PWM_BITS:0]     duty;
    logic [31:0]                     readdata_q, readdata_d, rmux;
    logic                            rdv_q, rdv_d;
    logic                            unused_wdata;

    assign unused_wdata = ^avs.avs_writedata;

    always_comb begin
        tick   = pcnt_q == PC_W'(PRESCALE - 1);
        wrap   = tick && (cnt_q == '1);
        pcnt_d = tick ? '0 : pcnt_q + 1'b1;
        cnt_d  = tick ? cnt_q + 1'b1 : cnt_q;
    end

    always_comb begin
        data_d  = data_q;
        mode_d  = mode_q;
        duty_we = '0;
        rmux    = '0;
        if (avs.avs_write && avs.avs_address == ADDR_W'(0)) data_d = avs.avs_writedata[N_CH-1:0];
        if (avs.avs_write && avs.avs_address == ADDR_W'(1)) mode_d = avs.avs_writedata[N_CH-1:0];
        if (avs.avs_address == ADDR_W'(0)) rmux[N_CH-1:0] = data_q;
        if (avs.avs_address == ADDR_W'(1)) rmux[N_CH-1:0] = mode_q;
        for (int i = 0; i < N_CH; i++) begin
            if (avs.avs_address == ADDR_W'(2 + i)) begin
                duty_we[i]        = avs.avs_write;
                rmux[PWM_BITS:0]  = duty[i];
            end
        end
        // readdata holds between reads; rmux sees only pre-write register values
        readdata_d = avs.avs_read ? rmux : readdata_q;
        rdv_d      = avs.avs_read;
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            pcnt_q     <= '0;
            cnt_q      <= '0;
            pwm_wrap_q <= 1'b0;
            data_q     <= '0;
            mode_q     <= '0;
            readdata_q <= '0;
            rdv_q      <= 1'b0;
        end else begin
            pcnt_q     <= pcnt_d;
            cnt_q      <= cnt_d;
            pwm_wrap_q <= wrap;
            data_q     <= data_d;
            mode_q     <= mode_d;
            readdata_q <= readdata_d;
            rdv_q      <= rdv_d;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        led_pwm_ch #(.PWM_BITS(PWM_BITS)) u_ch (
            .clk        (clk_clk),
            .rst        (reset_reset),
            .duty_we    (duty_we[g]),
            .duty_wdata (avs.avs_writedata[PWM_BITS:0]),
            .wrap       (wrap),
            .cnt        (cnt_q),
            .mode       (mode_q[g]),
            .data       (data_q[g]),
            .duty       (duty[g]),
            .led        (led_export[g])
        );
    end

    assign pwm_wrap              = pwm_wrap_q;
    assign avs.avs_readdata      = readdata_q;
    assign avs.avs_readdatavalid = rdv_q;
endmodule

// File: tb/tb_led_pwm_pio.sv
// Directed bench for led_pwm_pio with PRESCALE=2, PWM_BITS=4 (32-clk PWM period).
// Expected duty counts are hand-derived: high clocks = duty * PRESCALE.
module tb_led_pwm_pio;
    localparam int N_CH = 4, PWM_BITS = 4, PRESCALE = 2, ADDR_W = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N_CH-1:0] led;
    logic            pwm_wrap;
    int              n_chk = 0, n_pass = 0;
    int              highs, wpos;

    led_pwm_pio_if #(.ADDR_W(ADDR_W)) bus ();

    led_pwm_pio #(.N_CH(N_CH), .PWM_BITS(PWM_BITS), .PRESCALE(PRESCALE), .ADDR_W(ADDR_W)) dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .avs         (bus.slave),
        .led_export  (led),
        .pwm_wrap    (pwm_wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic bus_wr(input int addr, input logic [31:0] wd);
        @(negedge clk);
        bus.avs_address   = ADDR_W'(addr);
        bus.avs_writedata = wd;
        bus.avs_write     = 1'b1;
        @(negedge clk);
        bus.avs_write     = 1'b0;
    endtask

    task automatic bus_rd(input string tag, input int addr, input logic [31:0] exp);
        @(negedge clk);
        bus.avs_address = ADDR_W'(addr);
        bus.avs_read    = 1'b1;
        @(negedge clk);
        bus.avs_read    = 1'b0;
        chk({tag, "_rdv"}, {31'b0, bus.avs_readdatavalid}, 32'd1);
        chk(tag, bus.avs_readdata, exp);
    endtask

    task automatic wait_wrap(input string tag);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (pwm_wrap) break;
        end
        chk(tag, {31'b0, pwm_wrap}, 32'd1);
    endtask

    // 32 samples aligned to a period; optionally writes DUTY_0 at sample wr_at
    task automatic measure(input int wr_at, input logic [31:0] wv, output int h, output int wp);
        h  = 0;
        wp = -1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (led[0]) h++;
            if (pwm_wrap) wp = i;
            if (i == wr_at) begin
                bus.avs_address   = ADDR_W'(2);
                bus.avs_writedata = wv;
                bus.avs_write     = 1'b1;
            end else begin
                bus.avs_write     = 1'b0;
            end
        end
    endtask

    task automatic period(input string tag, input int wr_at, input logic [31:0] wv, input int exp_h);
        measure(wr_at, wv, highs, wpos);
        chk(tag, highs, exp_h);
        chk({tag, "_wrap"}, wpos, 31);
    endtask

    initial begin
        bus.avs_address = '0; bus.avs_write = 1'b0; bus.avs_writedata = '0; bus.avs_read = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_led", {28'b0, led}, 32'd0);
        chk("rst_wrap", {31'b0, pwm_wrap}, 32'd0);
        chk("rst_rdv", {31'b0, bus.avs_readdatavalid}, 32'd0);
        rst = 1'b0;

        // Case 1: all registers and unmapped addresses read 0
        for (int a = 0; a <= 2 + N_CH; a++) bus_rd($sformatf("rd0_a%0d", a), a, 32'd0);
        bus_rd("rd0_a15", 15, 32'd0);
        @(negedge clk);
        chk("rdv_idle", {31'b0, bus.avs_readdatavalid}, 32'd0);

        // Case 2: static output, upper write bits ignored
        bus_wr(1, 32'd0);
        bus_wr(0, 32'hFFFF_FFFA);
        @(negedge clk);
        chk("static_led", {28'b0, led}, 32'hA);
        bus_rd("rd_data", 0, 32'hA);
        chk("rdata_hold", bus.avs_readdata, 32'hA);

        // Same-cycle read and write returns the old value
        @(negedge clk);
        bus.avs_address = ADDR_W'(0); bus.avs_writedata = 32'h5;
        bus.avs_write = 1'b1; bus.avs_read = 1'b1;
        @(negedge clk);
        bus.avs_write = 1'b0; bus.avs_read = 1'b0;
        chk("rw_same_old", bus.avs_readdata, 32'hA);
        bus_rd("rw_same_new", 0, 32'h5);
        bus_wr(0, 32'hA);

        // Case 3: duty 5 -> 10 high / 22 low; channels 1..3 stay static
        bus_wr(2, 32'd5);
        bus_rd("rd_duty0", 2, 32'd5);
        bus_wr(1, 32'd1);
        bus_rd("rd_mode", 1, 32'd1);
        wait_wrap("wrap_a");
        wait_wrap("wrap_b");
        period("duty5", -1, 32'd0, 10);
        chk("static_ch", {29'b0, led[3:1]}, 32'b101);

        // Case 5: mid-period write applies at next wrap
        period("mid_wr_old", 3, 32'd12, 10);
        period("mid_wr_new", -1, 32'd0, 24);
        // A write in the wrap cycle itself is deferred one extra period
        period("wrapcyc_wr", 30, 32'd5, 24);
        period("wrapcyc_defer", -1, 32'd0, 24);
        period("wrapcyc_new", -1, 32'd0, 10);

        // Case 4: duty boundaries
        period("to_zero_old", 5, 32'd0, 10);
        period("duty0", -1, 32'd0, 0);
        period("to_full_old", 5, 32'd16, 0);
        period("duty16", -1, 32'd0, 32);
        bus_rd("rd_duty16", 2, 32'd16);

        // Case 6: asynchronous reset while output high and readdatavalid set
        @(negedge clk);
        bus.avs_address = ADDR_W'(1); bus.avs_read = 1'b1;
        @(negedge clk);
        bus.avs_read = 1'b0;
        chk("pre_rst_led", {31'b0, led[0]}, 32'd1);
        chk("pre_rst_rdv", {31'b0, bus.avs_readdatavalid}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_led", {28'b0, led}, 32'd0);
        chk("arst_wrap", {31'b0, pwm_wrap}, 32'd0);
        chk("arst_rdv", {31'b0, bus.avs_readdatavalid}, 32'd0);
        chk("arst_rdata", bus.avs_readdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus_rd("post_rst_data", 0, 32'd0);
        bus_rd("post_rst_mode", 1, 32'd0);
        bus_rd("post_rst_duty0", 2, 32'd0);
        @(negedge clk);
        chk("post_rst_led", {28'b0, led}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
